// File: rtl/shift_arb_pkg.sv
// Shared types for the shift arbiter: one shift request as carried from a requester
// port to the shared shifter.
package shift_arb_pkg;

    localparam int SHAMT_W = 5;

    typedef struct packed {
        logic [31:0]        d;
        logic [SHAMT_W-1:0] shamt;
        logic               dir;
        logic               ari;
    } shift_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or after i_ptr, wrapping.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    input  logic             i_en,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx
);

    logic w_found;
    int   w_j;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int k = 0; k < N; k++) begin
            w_j = (int'(i_ptr) + k) % N;
            if (i_en && !w_found && i_req[w_j]) begin
                w_found      = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx        = IDX_W'(w_j);
            end
        end
    end

endmodule

// File: rtl/shifter.sv
// Combinational 32-bit shifter: left, logical right, or right with bit 31 kept.
import shift_arb_pkg::*;

module shifter (
    input  logic [31:0]        i_d,
    input  logic [SHAMT_W-1:0] i_shamt,
    input  logic               i_dir,
    input  logic               i_ari,
    output logic [31:0]        o_q
);

    logic [31:0] w_lsl;
    logic [31:0] w_lsr;

    assign w_lsl = i_d << i_shamt;
    assign w_lsr = i_d >> i_shamt;

    // The arithmetic form only pins bit 31; it is not a full sign extension.
    always_comb begin
        o_q = w_lsl;
        if (i_dir) begin
            o_q = i_ari ? {i_d[31], w_lsr[30:0]} : w_lsr;
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one shifter among N_REQ requesters; results return through a single-entry
// output slot owned by the requester that was granted.
import shift_arb_pkg::*;

module shift_arbiter #(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*DATA_W-1:0]    req_d,
    input  logic [N_REQ*SHAMT_W-1:0]   req_shamt,
    input  logic [N_REQ-1:0]           req_dir,
    input  logic [N_REQ-1:0]           req_ari,
    output logic [N_REQ-1:0]           resp_valid,
    input  logic [N_REQ-1:0]           resp_ready,
    output logic [DATA_W-1:0]          resp_q,
    output logic                       busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]  r_owner;
    logic [31:0]       r_q;
    logic [IDX_W-1:0]  r_ptr;

    shift_req_t        w_req [N_REQ];
    shift_req_t        w_sel;
    logic              w_busy;
    logic              w_drain;
    logic              w_can_accept;
    logic              w_accept;
    logic [N_REQ-1:0]  w_grant;
    logic [IDX_W-1:0]  w_idx;
    logic [31:0]       w_shift_q;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_req[i].d     = req_d[i*DATA_W +: 32];
            w_req[i].shamt = req_shamt[i*SHAMT_W +: SHAMT_W];
            w_req[i].dir   = req_dir[i];
            w_req[i].ari   = req_ari[i];
        end
    end

    assign w_busy       = |r_owner;
    assign w_drain      = |(r_owner & resp_ready);
    // Gating with rst keeps req_ready low for the whole reset cycle.
    assign w_can_accept = (!w_busy || w_drain) && !rst;

    rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_rr_arbiter (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .i_en    (w_can_accept),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign w_accept = |w_grant;
    assign w_sel    = w_req[w_idx];

    shifter u_shifter (
        .i_d     (w_sel.d),
        .i_shamt (w_sel.shamt),
        .i_dir   (w_sel.dir),
        .i_ari   (w_sel.ari),
        .o_q     (w_shift_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= '0;
            r_q     <= '0;
            r_ptr   <= '0;
        end else if (w_accept) begin
            r_q     <= w_shift_q;
            r_owner <= w_grant;
            r_ptr   <= (w_idx == IDX_W'(N_REQ - 1)) ? '0 : w_idx + IDX_W'(1);
        end else if (w_drain) begin
            r_owner <= '0;
        end
    end

    assign req_ready  = w_grant;
    assign resp_valid = r_owner;
    assign resp_q     = r_q;
    assign busy       = w_busy;

endmodule
